sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two requesters: port 0 (MEM stage data access) and port 1 (auxiliary master, e.g. program loader / debug DMA).
- Sits between the EXE/MEM pipeline register and the SRAM controller. It sequences one transaction at a time and returns a one-cycle acknowledge with read data.
- Generates the pipeline stall for port 0, and enforces a watchdog timeout on the controller.

Parameters:
- ADDR_W, 32, address width of both ports and the controller.
- DATA_W, 32, data width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 highest.
- TIMEOUT, 64, maximum cycles in BUSY before a forced abort (≥ 2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 store data.
- p0_rdata  out  DATA_W  port 0 read data; valid with p0_ack.
- p0_ack  out  1  one-cycle completion pulse.
- p0_stall  out  1  p0_req & ~p0_ack (combinational); drives the pipeline freeze.
- p1_req / p1_we / p1_addr / p1_wdata / p1_rdata / p1_ack  same as port 0, for port 1.
- mem_read_en  out  1  controller read enable.
- mem_write_en  out  1  controller write enable.
- mem_addr  out  ADDR_W  controller address.
- mem_wdata  out  DATA_W  controller write data.
- mem_rdata  in  DATA_W  controller read data.
- mem_ready  in  1  controller ready: low while busy, high on the completing cycle.
- timeout_err  out  1  sticky; set on a watchdog abort.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, last_grant=1, counter=0.
  - All outputs 0, including p*_rdata and timeout_err.
- FSM states: IDLE, BUSY, ACK.
- IDLE: if any req is high, pick a winner, latch grant, we, addr and wdata into registers, go to BUSY. Otherwise stay.
- Arbitration rules:
  - RR_EN=1: on contention the port ≠ last_grant wins.
  - RR_EN=0: port 0 always wins.
  - A single requester always wins.
- BUSY:
  - mem_read_en = ~we_r, mem_write_en = we_r, from the latched registers. mem_addr and mem_wdata are driven from the latched registers; they are stable for the whole transaction even if requester inputs change.
  - counter increments every cycle.
  - A cycle with mem_ready=1 and enable asserted is the completion:
    - Capture mem_rdata into the granted port's rdata register; writes leave rdata unchanged.
    - Go to ACK.
    - Completion is not recognised in the first BUSY cycle. That cycle only issues, because the controller reports ready while idle.
  - If counter reaches TIMEOUT-1 without completion: set timeout_err, load rdata with 0, go to ACK (abort).
- ACK:
  - Enables are 0.
  - Granted port's ack=1 for exactly this cycle.
  - last_grant ← grant, counter ← 0, go to IDLE.
  - Back-to-back latency: a new transaction can start at the earliest in the cycle after ACK.
- Minimum latency: req high in cycle 0 → BUSY in cycle 1 → completion ≥ cycle 2 → ack ≥ cycle 3.
- A requester dropping req mid-transaction has no effect; the transaction completes and ack is still pulsed.
- Both acks are never high simultaneously.
- A non-granted port sees no side effects and keeps waiting. Its rdata register holds its previous value.
- timeout_err is cleared only by reset.
- Reset mid-BUSY drops enables immediately (asynchronous). No ack is issued for the aborted transaction.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2) and the port index constants P0=1'b0, P1=1'b1.
- One natural sub-module, rr_arbiter2: the combinational 2-way winner select from req[1:0], last_grant and RR_EN. The FSM, counter and datapath registers stay in sram_arbiter.

Test Plan:
- Single read: p0 read addr 0x10. Controller model holds ready low 4 cycles, then ready=1 with rdata 0xDEADBEEF → p0_ack one cycle later, p0_rdata=0xDEADBEEF, p0_stall high until the ack cycle.
- Contention, RR_EN=1: p0 and p1 request together from reset → p0 served first (last_grant=1), then p1. Keep both asserting → acks alternate p0, p1, p0, p1.
- Fixed priority, RR_EN=0: p0 requests continuously, p1 requests too → p1 is never acknowledged while p0_req stays high. Drop p0 → p1 served next.
- Write stability: p1 write addr 0x20, wdata 0x12345678. Change p1_addr/p1_wdata during BUSY → mem_addr/mem_wdata stay 0x20/0x12345678 until completion; p1_rdata unchanged.
- Timeout: controller never asserts ready, TIMEOUT=8 → ack after 8 BUSY cycles, rdata=0, timeout_err=1 and sticky across later successful transactions.
- Reset mid-BUSY: assert rst=0 in the 2nd BUSY cycle → enables, acks and timeout_err go 0 immediately. After release, state IDLE and a fresh request is served normally.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding and port indices.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way winner select: round-robin against last_grant, or fixed priority to port 0.
module rr_arbiter2
  import sram_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

  always_comb begin
    winner = P0;
    if (req == 2'b10) begin
      winner = P1;
    end else if (req == 2'b11) begin
      // On contention the port that was not served last goes first.
      winner = (RR_EN != 0) ? ~last_grant : P0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM controller: one transaction at a time,
// one-cycle ack with read data, pipeline stall for port 0 and a sticky watchdog abort.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              terr_q, terr_d;
  logic              winner;

  rr_arbiter2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .req       ({p1_req, p0_req}),
    .last_grant(last_grant_q),
    .winner    (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= P0;
      last_grant_q <= P1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      terr_q       <= terr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    terr_d       = terr_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d = BUSY;
          grant_d = winner;
          we_d    = (winner == P1) ? p1_we    : p0_we;
          addr_d  = (winner == P1) ? p1_addr  : p0_addr;
          wdata_d = (winner == P1) ? p1_wdata : p0_wdata;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // The controller reports ready while idle, so the issue cycle (cnt 0) never completes.
        if ((cnt_q != '0) && mem_ready) begin
          state_d = ACK;
          if (!we_q) begin
            if (grant_q == P1) p1_rdata_d = mem_rdata;
            else               p0_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ACK;
          terr_d  = 1'b1;
          if (grant_q == P1) p1_rdata_d = '0;
          else               p0_rdata_d = '0;
        end
      end
      ACK: begin
        last_grant_d = grant_q;
        cnt_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read_en  = (state_q == BUSY) && !we_q;
  assign mem_write_en = (state_q == BUSY) && we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign p0_ack       = (state_q == ACK) && (grant_q == P0);
  assign p1_ack       = (state_q == ACK) && (grant_q == P1);
  assign p0_stall     = p0_req && !p0_ack;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign timeout_err  = terr_q;

endmodule
